// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson phase decoder: FSM state encoding,
// sample classification codes, the 8-entry legal Johnson code table and
// the default lock threshold.
package johnson_pkg;

   // Sequence checker state (kept as plain constants for legacy tools)
   typedef logic [0:0] fsm_state_t;
   localparam fsm_state_t ST_UNLOCKED = 1'b0;
   localparam fsm_state_t ST_LOCKED   = 1'b1;

   // Classification of one sample against the previously stored code
   typedef logic [1:0] sample_class_t;
   localparam sample_class_t CLS_LOAD    = 2'd0;
   localparam sample_class_t CLS_HOLD    = 2'd1;
   localparam sample_class_t CLS_ADVANCE = 2'd2;
   localparam sample_class_t CLS_ERROR   = 2'd3;

   // Consecutive legal advances needed before reporting lock
   localparam int unsigned LOCK_CNT_DEFAULT = 4;

   // Legal codes of a 4-bit Johnson counter, indexed by phase
   localparam logic [3:0] JOHNSON_CODES [8] = '{
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001
   };

   // One-hot expansion of a phase index
   function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

endpackage

// File: rtl/johnson_code_dec.sv
// Combinational Johnson code lookup: reports whether a 4-bit code is one of
// the eight legal counter states and, if so, its phase index (0 otherwise).
module johnson_code_dec
   import johnson_pkg::*;
(
   input  logic [3:0] code,
   output logic       legal,
   output logic [2:0] idx
);

   // Match the code against every table entry; entries are unique so at
   // most one index contributes to the OR.
   always_comb begin
      legal = 1'b0;
      idx   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         legal = legal | (code == JOHNSON_CODES[i]);
         idx   = idx | ((code == JOHNSON_CODES[i]) ? 3'(i) : 3'd0);
      end
   end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson phase decoder: registers the one-hot and binary phase of the
// upstream 4-bit Johnson counter, checks that consecutive samples follow the
// counting sequence, reports lock after LOCK_CNT clean advances and pulses
// err on any skipped or illegal code.
// Optional feature macro: JOHNSON_DEC_ERR_CNT_EN enables the saturating
// 8-bit error counter; without it err_cnt is constant zero.
module johnson_phase_decoder
   import johnson_pkg::*;
#(
   parameter int unsigned LOCK_CNT = LOCK_CNT_DEFAULT
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] john_q,
   output logic [7:0] phase_oh,
   output logic [2:0] phase_idx,
   output logic       locked,
   output logic       err,
   output logic [7:0] err_cnt
);

   localparam logic [3:0] LOCK_CNT_W = 4'(LOCK_CNT);

   logic          cur_legal_s;
   logic [2:0]    cur_idx_s;
   logic          prev_legal_s;
   logic [2:0]    prev_idx_s;
   logic [3:0]    prev_code_r;
   logic          load_r;
   fsm_state_t    state_r;
   fsm_state_t    state_nxt_s;
   logic [3:0]    run_cnt_r;
   logic [3:0]    run_nxt_s;
   sample_class_t class_s;
   logic [7:0]    phase_oh_r;
   logic [2:0]    phase_idx_r;
   logic          err_r;
   logic          locked_r;

   johnson_code_dec u_cur_dec (
      .code  (john_q),
      .legal (cur_legal_s),
      .idx   (cur_idx_s)
   );

   johnson_code_dec u_prev_dec (
      .code  (prev_code_r),
      .legal (prev_legal_s),
      .idx   (prev_idx_s)
   );

   // Classify the incoming sample; illegal codes always error, and a legal
   // code after reset or after an illegal code is only loaded.
   always_comb begin
      class_s = CLS_LOAD;
      if (!cur_legal_s) begin
         class_s = CLS_ERROR;
      end else if (load_r || !prev_legal_s) begin
         class_s = CLS_LOAD;
      end else if (cur_idx_s == prev_idx_s) begin
         class_s = CLS_HOLD;
      end else if (cur_idx_s == prev_idx_s + 3'd1) begin
         class_s = CLS_ADVANCE;
      end else begin
         class_s = CLS_ERROR;
      end
   end

   // Lock FSM and run counter next-state logic
   always_comb begin
      state_nxt_s = state_r;
      run_nxt_s   = run_cnt_r;
      case (state_r)
         ST_UNLOCKED: begin
            if (class_s == CLS_ADVANCE) begin
               run_nxt_s = run_cnt_r + 4'd1;
               if (run_cnt_r + 4'd1 == LOCK_CNT_W) begin
                  state_nxt_s = ST_LOCKED;
               end else begin
                  state_nxt_s = ST_UNLOCKED;
               end
            end else if (class_s == CLS_ERROR) begin
               run_nxt_s = 4'd0;
            end else begin
               run_nxt_s = run_cnt_r;
            end
         end
         ST_LOCKED: begin
            if (class_s == CLS_ERROR) begin
               state_nxt_s = ST_UNLOCKED;
               run_nxt_s   = 4'd0;
            end else begin
               state_nxt_s = ST_LOCKED;
            end
         end
         default: begin
            state_nxt_s = ST_UNLOCKED;
            run_nxt_s   = 4'd0;
         end
      endcase
   end

   // Sample history, FSM state and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_code_r <= 4'b0000;
         load_r      <= 1'b1;
         state_r     <= ST_UNLOCKED;
         run_cnt_r   <= 4'd0;
         phase_oh_r  <= 8'h00;
         phase_idx_r <= 3'd0;
         err_r       <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         prev_code_r <= cur_legal_s ? john_q : prev_code_r;
         load_r      <= ~cur_legal_s;
         state_r     <= state_nxt_s;
         run_cnt_r   <= run_nxt_s;
         phase_oh_r  <= cur_legal_s ? idx_to_onehot(cur_idx_s) : 8'h00;
         phase_idx_r <= cur_idx_s;
         err_r       <= (class_s == CLS_ERROR);
         locked_r    <= (state_nxt_s == ST_LOCKED);
      end
   end

   assign phase_oh  = phase_oh_r;
   assign phase_idx = phase_idx_r;
   assign err       = err_r;
   assign locked    = locked_r;

`ifdef JOHNSON_DEC_ERR_CNT_EN
   logic [7:0] err_cnt_r;

   // Saturating count of error pulses, updated together with err
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r <= 8'h00;
      end else if ((class_s == CLS_ERROR) && (err_cnt_r != 8'hFF)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt = err_cnt_r;
`else
   assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder: a table of directed samples
// with hand-computed outputs, plus hand-written hold, async reset and
// error-saturation sequences.
module tb_johnson_phase_decoder;

   typedef struct {
      logic [3:0] code;
      logic [2:0] idx;
      logic [7:0] oh;
      logic       err;
      logic       locked;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [3:0] john_q;
   logic [7:0] phase_oh;
   logic [2:0] phase_idx;
   logic       locked;
   logic       err;
   logic [7:0] err_cnt;

   int checks   = 0;
   int failures = 0;
   int exp_errs = 0;
   vec_t vecs[$];

   johnson_phase_decoder #(.LOCK_CNT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .john_q    (john_q),
      .phase_oh  (phase_oh),
      .phase_idx (phase_idx),
      .locked    (locked),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] exp_cnt(input int n);
`ifdef JOHNSON_DEC_ERR_CNT_EN
      return (n > 255) ? 8'hFF : 8'(n);
`else
      return (n >= 0) ? 8'h00 : 8'h00;
`endif
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input vec_t v);
      check({tag, ".idx"},    {5'd0, phase_idx}, {5'd0, v.idx});
      check({tag, ".oh"},     phase_oh,          v.oh);
      check({tag, ".err"},    {7'd0, err},       {7'd0, v.err});
      check({tag, ".locked"}, {7'd0, locked},    {7'd0, v.locked});
      check({tag, ".errcnt"}, err_cnt,           exp_cnt(exp_errs));
   endtask

   // Drive one sample, let it be clocked in, then look at the outputs
   task automatic step(input logic [3:0] code);
      john_q = code;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] c, input logic [2:0] i, input logic [7:0] o,
                      input logic e, input logic l);
      vec_t v;
      v.code = c; v.idx = i; v.oh = o; v.err = e; v.locked = l;
      vecs.push_back(v);
   endtask

   initial begin
      vec_t hv;
      // release, lock, wrap
      add(4'b0001, 3'd7, 8'h80, 1'b0, 1'b0);
      add(4'b0000, 3'd0, 8'h01, 1'b0, 1'b0);
      add(4'b1000, 3'd1, 8'h02, 1'b0, 1'b0);
      add(4'b1100, 3'd2, 8'h04, 1'b0, 1'b0);
      add(4'b1110, 3'd3, 8'h08, 1'b0, 1'b1);
      add(4'b1111, 3'd4, 8'h10, 1'b0, 1'b1);
      add(4'b0111, 3'd5, 8'h20, 1'b0, 1'b1);
      add(4'b0011, 3'd6, 8'h40, 1'b0, 1'b1);
      add(4'b0001, 3'd7, 8'h80, 1'b0, 1'b1);
      add(4'b0000, 3'd0, 8'h01, 1'b0, 1'b1);
      add(4'b1000, 3'd1, 8'h02, 1'b0, 1'b1);
      // illegal code while locked, then fresh load and relock
      add(4'b0101, 3'd0, 8'h00, 1'b1, 1'b0);
      add(4'b1100, 3'd2, 8'h04, 1'b0, 1'b0);
      add(4'b1110, 3'd3, 8'h08, 1'b0, 1'b0);
      add(4'b1111, 3'd4, 8'h10, 1'b0, 1'b0);
      add(4'b0111, 3'd5, 8'h20, 1'b0, 1'b0);
      add(4'b0011, 3'd6, 8'h40, 1'b0, 1'b1);
      add(4'b0001, 3'd7, 8'h80, 1'b0, 1'b1);
      add(4'b0000, 3'd0, 8'h01, 1'b0, 1'b1);
      add(4'b1000, 3'd1, 8'h02, 1'b0, 1'b1);
      // skip 1000 -> 1110, then relock after four advances
      add(4'b1110, 3'd3, 8'h08, 1'b1, 1'b0);
      add(4'b1111, 3'd4, 8'h10, 1'b0, 1'b0);
      add(4'b0111, 3'd5, 8'h20, 1'b0, 1'b0);
      add(4'b0011, 3'd6, 8'h40, 1'b0, 1'b0);
      add(4'b0001, 3'd7, 8'h80, 1'b0, 1'b1);
      add(4'b0000, 3'd0, 8'h01, 1'b0, 1'b1);
      add(4'b1000, 3'd1, 8'h02, 1'b0, 1'b1);
      add(4'b1100, 3'd2, 8'h04, 1'b0, 1'b1);

      // reset state
      rst    = 1'b1;
      john_q = 4'b0000;
      #12;
      hv.code = 4'b0000; hv.idx = 3'd0; hv.oh = 8'h00; hv.err = 1'b0; hv.locked = 1'b0;
      check_all("reset", hv);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // directed table
      foreach (vecs[k]) begin
         step(vecs[k].code);
         if (vecs[k].err) exp_errs++;
         check_all($sformatf("vec%0d", k), vecs[k]);
      end

      // hold 1100 for ten cycles while locked
      hv.code = 4'b1100; hv.idx = 3'd2; hv.oh = 8'h04; hv.err = 1'b0; hv.locked = 1'b1;
      for (int h = 0; h < 10; h++) begin
         step(4'b1100);
         check_all($sformatf("hold%0d", h), hv);
      end

      // asynchronous reset between edges while locked
      #3;
      rst = 1'b1;
      #1;
      exp_errs = 0;
      hv.code = 4'b0000; hv.idx = 3'd0; hv.oh = 8'h00; hv.err = 1'b0; hv.locked = 1'b0;
      check_all("async_rst", hv);
      @(negedge clk);
      rst = 1'b0;

      // first sample after reset is a load even though it is not a successor
      step(4'b1000);
      hv.idx = 3'd1; hv.oh = 8'h02; hv.err = 1'b0; hv.locked = 1'b0;
      check_all("post_rst_load", hv);
      step(4'b1100);
      hv.idx = 3'd2; hv.oh = 8'h04;
      check_all("post_rst_adv", hv);

      // 300 consecutive illegal samples: err every cycle, counter saturates
      for (int n = 0; n < 300; n++) begin
         step(((n % 2) == 0) ? 4'b0101 : 4'b1010);
         exp_errs++;
         if (n == 0 || n == 299) begin
            hv.idx = 3'd0; hv.oh = 8'h00; hv.err = 1'b1; hv.locked = 1'b0;
            check_all($sformatf("illegal%0d", n), hv);
         end
      end
      check("sat_cnt", err_cnt, exp_cnt(300));

      // next legal code loads cleanly
      step(4'b0000);
      hv.idx = 3'd0; hv.oh = 8'h01; hv.err = 1'b0; hv.locked = 1'b0;
      check_all("after_illegal_load", hv);
      step(4'b1000);
      hv.idx = 3'd1; hv.oh = 8'h02;
      check_all("after_illegal_adv", hv);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive legal advances (1..15) required to assert locked.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port john_q, input, 4 bits: the Johnson count from the upstream 4-bit counter, sampled every clk.
REQ-005 SHALL have port phase_oh, output, 8 bits: registered one-hot phase of the last sampled code.
REQ-006 SHALL have port phase_idx, output, 3 bits: registered binary phase index of the last sampled code.
REQ-007 SHALL have port locked, output, 1 bit: the sequence checker is in LOCKED.
REQ-008 SHALL have port err, output, 1 bit: a one-cycle pulse on any sequence or code error.
REQ-009 SHALL have port err_cnt, output, 8 bits: the saturating error count (see Configuration).

Function
REQ-010 SHALL decode legal codes 0000,1000,1100,1110,1111,0111,0011,0001 to phase_idx 0..7 and phase_oh = 1<<phase_idx.
REQ-011 SHALL treat the other 8 codes as illegal: phase_oh=8'h00, phase_idx=0, err=1 in the following cycle.
REQ-012 SHALL have a latency of exactly one clk from john_q to phase_oh, phase_idx, err and locked.
REQ-013 SHALL store the previous sampled code; the successor of idx n is idx (n+1) mod 8, so 0001->0000 wraps legally.
REQ-014 SHALL classify each sample against the previous one as HOLD (same code, no error, run count unchanged), ADVANCE (legal successor, run count +1), or ERROR (any other legal code, or any illegal code).
REQ-015 SHALL treat the first sample after reset as a load: no advance, no error, previous-code register loaded.
REQ-016 SHALL implement a two-state FSM, UNLOCKED and LOCKED; reset state UNLOCKED.
REQ-017 SHALL, in UNLOCKED, increment the run count on ADVANCE, clear it on ERROR, and enter LOCKED on the cycle the run count reaches LOCK_CNT.
REQ-018 SHALL, in LOCKED, stay in LOCKED on HOLD or ADVANCE, and on ERROR return to UNLOCKED with the run count cleared.
REQ-019 SHALL, after an illegal code, accept the next legal code as a fresh load (no second err for that code).
REQ-020 SHALL pulse err on ERROR in either FSM state, with the pulse lasting exactly one cycle per erroneous sample.

Reset
REQ-021 SHALL, while rst=1, force immediately: phase_oh=8'h00, phase_idx=0, locked=0, err=0, err_cnt=0, run count=0, first-sample flag set.
REQ-022 SHALL, on rst asserted mid-sequence, discard all history; the first sample after release is a load per REQ-015.

Configuration
REQ-023 SHALL gate err_cnt with macro JOHNSON_DEC_ERR_CNT_EN: when defined, err_cnt increments on each err pulse and saturates at 8'hFF; when undefined, err_cnt is tied to 8'h00 and no counter flops exist.

Structure
REQ-024 SHALL place the FSM state typedef, the 8-entry code table, and the LOCK_CNT default in the shared package johnson_pkg.
REQ-025 SHALL use one combinational sub-module, johnson_code_dec (code -> legal flag, idx), instantiated for both the current and the previous code.

Verification
REQ-026 SHALL test release from reset with the upstream counter (0001,0000,1000,1100,...): phase_idx 7,0,1,2 with one-cycle lag; locked=1 after the 4th ADVANCE; err never asserts.
REQ-027 SHALL test an illegal code: inject 0101 while LOCKED -> phase_oh=00, err pulses once, locked=0, err_cnt=1; the next legal code loads without error.
REQ-028 SHALL test a skip: 1000 then 1110 -> err pulses once, the FSM goes to UNLOCKED, and it relocks after 4 further ADVANCEs.
REQ-029 SHALL test a hold: repeat 1100 for 10 cycles while LOCKED -> locked stays 1, err stays 0, phase_idx stays 2.
REQ-030 SHALL test wrap and saturation: 0001->0000 gives no err; 300 forced errors give err_cnt=8'hFF with the macro defined and 8'h00 without it.
REQ-031 SHALL test reset: assert rst asynchronously between clock edges while LOCKED -> all outputs clear before the next edge.
